// File: rtl/adc_decimator.sv
// Two-channel boxcar decimator: averages 2^k valid ADC sample pairs per channel
// and emits each averaged pair with a one-cycle o_sample strobe.
module adc_decimator #(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int LOG2_DECIM_MAX   = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_enable,
    input  logic                               i_valid,
    input  logic signed [ZMOD_DATA_SIZE-1:0]   i_data_ch1,
    input  logic signed [ZMOD_DATA_SIZE-1:0]   i_data_ch2,
    input  logic        [IAGC_STATUS_SIZE-1:0] i_iagc_status,
    input  logic        [2:0]                  i_decim_log2,
    output logic signed [ZMOD_DATA_SIZE-1:0]   o_data_ch1,
    output logic signed [ZMOD_DATA_SIZE-1:0]   o_data_ch2,
    output logic        [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic                               o_sample,
    output logic                               o_overrange
);

    localparam int AW = ZMOD_DATA_SIZE + LOG2_DECIM_MAX;
    localparam int KW = $clog2(LOG2_DECIM_MAX + 1);
    localparam int CW = (LOG2_DECIM_MAX > 0) ? LOG2_DECIM_MAX : 1;

    localparam logic signed [ZMOD_DATA_SIZE-1:0] CODE_MAX = {1'b0, {(ZMOD_DATA_SIZE-1){1'b1}}};
    localparam logic signed [ZMOD_DATA_SIZE-1:0] CODE_MIN = {1'b1, {(ZMOD_DATA_SIZE-1){1'b0}}};

    // state    | meaning
    // ST_IDLE  | disabled; block state held cleared, outputs hold
    // ST_ACCUM | enabled; valid samples accumulate toward a block
    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    state_t                              state_q, state_d;
    logic signed [AW-1:0]                acc1_q, acc1_d, acc2_q, acc2_d;
    logic        [CW-1:0]                cnt_q, cnt_d;
    logic        [KW-1:0]                k_q, k_d;
    logic                                ovr_q, ovr_d;
    logic signed [ZMOD_DATA_SIZE-1:0]    data1_q, data1_d, data2_q, data2_d;
    logic        [IAGC_STATUS_SIZE-1:0]  status_q, status_d;
    logic                                sample_q, sample_d;
    logic                                overrange_q, overrange_d;

    logic                                accept, first, last, hit;
    logic        [KW-1:0]                k_req, k_cur;
    logic signed [AW-1:0]                sum1, sum2, shift1, shift2;

    always_comb begin
        accept = i_enable && i_valid && (state_q == ST_ACCUM);
        first  = (cnt_q == '0);
        k_req  = (int'(i_decim_log2) > LOG2_DECIM_MAX) ? KW'(LOG2_DECIM_MAX) : KW'(i_decim_log2);
        // The ratio in force for this sample: fresh request on a block's first sample.
        k_cur  = first ? k_req : k_q;
        last   = (cnt_q == CW'((32'd1 << k_cur) - 32'd1));
        hit    = (i_data_ch1 == CODE_MAX) || (i_data_ch1 == CODE_MIN) ||
                 (i_data_ch2 == CODE_MAX) || (i_data_ch2 == CODE_MIN);
        sum1   = acc1_q + {{LOG2_DECIM_MAX{i_data_ch1[ZMOD_DATA_SIZE-1]}}, i_data_ch1};
        sum2   = acc2_q + {{LOG2_DECIM_MAX{i_data_ch2[ZMOD_DATA_SIZE-1]}}, i_data_ch2};
        shift1 = sum1 >>> k_cur;
        shift2 = sum2 >>> k_cur;

        state_d     = state_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        ovr_d       = ovr_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        status_d    = status_q;
        sample_d    = 1'b0;
        overrange_d = overrange_q;

        if (!i_enable) begin
            state_d = ST_IDLE;
            acc1_d  = '0;
            acc2_d  = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            state_d = ST_ACCUM;
            if (accept) begin
                if (first) k_d = k_req;
                if (last) begin
                    data1_d     = shift1[ZMOD_DATA_SIZE-1:0];
                    data2_d     = shift2[ZMOD_DATA_SIZE-1:0];
                    status_d    = i_iagc_status;
                    overrange_d = ovr_q | hit;
                    sample_d    = 1'b1;
                    acc1_d      = '0;
                    acc2_d      = '0;
                    cnt_d       = '0;
                    ovr_d       = 1'b0;
                end else begin
                    acc1_d = sum1;
                    acc2_d = sum2;
                    cnt_d  = cnt_q + 1'b1;
                    ovr_d  = ovr_q | hit;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            acc1_q      <= '0;
            acc2_q      <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            ovr_q       <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            status_q    <= '0;
            sample_q    <= 1'b0;
            overrange_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            ovr_q       <= ovr_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            status_q    <= status_d;
            sample_q    <= sample_d;
            overrange_q <= overrange_d;
        end
    end

    assign o_data_ch1    = data1_q;
    assign o_data_ch2    = data2_q;
    assign o_iagc_status = status_q;
    assign o_sample      = sample_q;
    assign o_overrange   = overrange_q;

endmodule

// File: doc/adc_decimator.md
Name: adc_decimator

Overview:
- Capture-side counterpart of the DAC sample/hold path. Takes raw two-channel Zmod ADC samples, averages 2^k consecutive valid samples per channel (boxcar decimation), and emits one averaged pair with a single-cycle o_sample strobe.
- o_sample and the data outputs connect directly to the sample-enable and data inputs of the downstream DAC sampler and IAGC logic.
- IAGC status is carried alongside each output sample.

Parameters:
- ZMOD_DATA_SIZE, 14: width of each channel sample, signed two's complement.
- IAGC_STATUS_SIZE, 4: width of the IAGC status word.
- LOG2_DECIM_MAX, 4: maximum decimation exponent. Max ratio is 2^LOG2_DECIM_MAX = 16.

Ports:
- i_clock, input, 1: single clock; all logic on its rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_enable, input, 1: decimator run enable.
- i_valid, input, 1: a new ADC sample pair is present this cycle.
- i_data_ch1, input, ZMOD_DATA_SIZE: channel 1 ADC sample, signed.
- i_data_ch2, input, ZMOD_DATA_SIZE: channel 2 ADC sample, signed.
- i_iagc_status, input, IAGC_STATUS_SIZE: IAGC status accompanying the input.
- i_decim_log2, input, 3: requested exponent k; ratio N = 2^k.
- o_data_ch1, output, ZMOD_DATA_SIZE: averaged channel 1, signed.
- o_data_ch2, output, ZMOD_DATA_SIZE: averaged channel 2, signed.
- o_iagc_status, output, IAGC_STATUS_SIZE: status latched with the last sample of the block.
- o_sample, output, 1: one-cycle strobe; outputs updated this cycle.
- o_overrange, output, 1: block contained a full-scale input; valid when o_sample is high, held otherwise.

Behaviour:
- Reset: all outputs 0; accumulators 0; sample counter 0; state IDLE. Reset takes priority over all other inputs in the same cycle.
- States:
  - IDLE: i_enable = 0. Accumulators and counter held at 0. o_sample = 0. Data, status and overrange outputs hold their last values.
  - ACCUM: i_enable = 1.
  - IDLE -> ACCUM on the first cycle i_enable = 1. ACCUM -> IDLE whenever i_enable = 0.
- Disable mid-block: the partial block is discarded (accumulators and counter cleared) and no strobe is produced. On re-enable, accumulation starts a fresh block.
- Ratio latch: k_eff = min(i_decim_log2, LOG2_DECIM_MAX), latched on the first accepted sample of each block. Changes to i_decim_log2 mid-block take effect at the next block.
- Accumulators: signed, ZMOD_DATA_SIZE + LOG2_DECIM_MAX bits per channel, sign-extended adds, cannot overflow. Only cycles with i_valid = 1 in ACCUM advance the counter; i_valid = 0 cycles are ignored.
- Block completion on the Nth accepted sample (counter == N-1):
  - Each channel: sum = acc + sign-extended input; output = sum arithmetic-shifted right by k_eff, truncating toward minus infinity, low ZMOD_DATA_SIZE bits.
  - o_iagc_status = i_iagc_status of that cycle.
  - o_overrange = OR over the block of any input on either channel equal to the most-positive or most-negative code.
  - Accumulators, counter and overrange tracker cleared.
  - o_sample = 1 in the next cycle only. Latency is one clock from the completing input to the strobe and updated outputs.
- k_eff = 0: pass-through. Every valid input produces a strobe one cycle later with identical data.
- Back-to-back: with continuous i_valid and N = 1, o_sample is high every cycle. With N > 1, strobes are spaced exactly N valid cycles apart.
- o_sample is never high for two consecutive cycles unless N = 1.

Test Plan:
- Reset then enable, k=2, four valid pairs ch1=100,101,102,103 and ch2=-4,-4,-4,-5 -> single o_sample one cycle after the 4th; o_data_ch1 = 101, o_data_ch2 = -5 (floor of -17/4); o_overrange = 0.
- k=0, continuous i_valid with ch1 = 1,2,3 -> o_sample high three consecutive cycles; o_data_ch1 = 1,2,3, each one cycle delayed.
- k=4, 16 samples ch1 = 8191 with idle i_valid=0 gaps between them -> o_sample only after the 16th valid; o_data_ch1 = 8191; o_overrange = 1.
- k=3, drop i_enable after 5 samples, re-enable, feed 8 samples of 10 -> no strobe for the partial block; then o_data_ch1 = 10.
- i_decim_log2 = 7 -> clamped to 4; first strobe after 16 samples. Change k from 4 to 1 after 3 samples -> current block still completes at 16, next block at 2.
- Assert i_reset mid-block with i_valid high -> next cycle all outputs 0, no strobe; the following block starts from zero.
